// File: rtl/ssp_talker_fifo.sv
// ssp_talker_fifo: full-duplex synchronous serial port with per-direction FIFOs.
// WIDTH-bit words are sent MSB-first behind a one-tick frame sync. Received
// frames land in an RX FIFO with a valid/ready handshake and a sticky overrun flag.
// Optional build macro SSP_LOOPBACK_EN adds a 'loopback' input that feeds the
// TX serial outputs back into the RX side internally.
`timescale 1ns/1ps
module ssp_talker_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             pclk,
  input  logic             clear,
  input  logic [WIDTH-1:0] txdata,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rxdata,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  input  logic             sspclkin,
  input  logic             sspfssin,
  input  logic             ssprxd,
`ifdef SSP_LOOPBACK_EN
  input  logic             loopback,
`endif
  output logic             sspclkout,
  output logic             sspfssout,
  output logic             ssptxd,
  output logic             sspoe_b,
  output logic             tx_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(WIDTH);

  typedef enum logic [1:0] {TX_IDLE, TX_FSS, TX_DATA} tx_state_e;
  typedef enum logic {RX_HUNT, RX_RECV} rx_state_e;

  // Serial clock and TX engine
  logic             sclk_q, sclk_d;
  logic             tick;
  tx_state_e        tx_state_q, tx_state_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [BW-1:0]    tx_bitcnt_q, tx_bitcnt_d;
  logic             fss_q, fss_d;
  logic             txd_q, txd_d;
  logic             oe_b_q, oe_b_d;

  // TX FIFO
  logic [WIDTH-1:0] txf_mem_q [DEPTH];
  logic [AW-1:0]    txf_wr_q, txf_wr_d, txf_rd_q, txf_rd_d;
  logic [CW-1:0]    txf_cnt_q, txf_cnt_d;
  logic             tx_push, tx_pop;

  // RX engine
  logic             rx_clk_in, rx_fss_in, rx_dat_in;
  logic             rclk_q, rclk_d;
  logic             sample;
  rx_state_e        rx_state_q, rx_state_d;
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [BW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [WIDTH-1:0] rx_word;
  logic             rx_push;

  // RX FIFO
  logic [WIDTH-1:0] rxf_mem_q [DEPTH];
  logic [AW-1:0]    rxf_wr_q, rxf_wr_d, rxf_rd_q, rxf_rd_d;
  logic [CW-1:0]    rxf_cnt_q, rxf_cnt_d;
  logic             rxf_full, rx_pop, rx_wr;
  logic [WIDTH-1:0] rxdata_q, rxdata_d;
  logic             ovr_q, ovr_d;

  // TX FIFO bookkeeping and TX frame FSM; FSM only advances on sspclkout 0->1
  always_comb begin
    sclk_d      = ~sclk_q;
    tick        = ~sclk_q;
    tx_ready    = (txf_cnt_q != CW'(DEPTH));
    tx_push     = tx_valid & tx_ready;
    tx_pop      = 1'b0;
    tx_state_d  = tx_state_q;
    tx_shift_d  = tx_shift_q;
    tx_bitcnt_d = tx_bitcnt_q;
    fss_d       = fss_q;
    txd_d       = txd_q;
    oe_b_d      = oe_b_q;
    if (tick) begin
      case (tx_state_q)
        TX_IDLE: begin
          if (txf_cnt_q != '0) begin
            tx_pop     = 1'b1;
            tx_shift_d = txf_mem_q[txf_rd_q];
            fss_d      = 1'b1;
            tx_state_d = TX_FSS;
          end
        end
        TX_FSS: begin
          fss_d       = 1'b0;
          txd_d       = tx_shift_q[WIDTH-1];
          oe_b_d      = 1'b0;
          tx_bitcnt_d = BW'(WIDTH - 1);
          tx_state_d  = TX_DATA;
        end
        TX_DATA: begin
          if (tx_bitcnt_q == '0) begin
            oe_b_d     = 1'b1;
            txd_d      = 1'b0;
            tx_state_d = TX_IDLE;
            // The idle check is folded into the end-of-frame tick so queued
            // frames follow with no gap.
            if (txf_cnt_q != '0) begin
              tx_pop     = 1'b1;
              tx_shift_d = txf_mem_q[txf_rd_q];
              fss_d      = 1'b1;
              tx_state_d = TX_FSS;
            end
          end else begin
            tx_shift_d  = {tx_shift_q[WIDTH-2:0], 1'b0};
            txd_d       = tx_shift_q[WIDTH-2];
            tx_bitcnt_d = tx_bitcnt_q - BW'(1);
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
    txf_wr_d  = tx_push ? txf_wr_q + AW'(1) : txf_wr_q;
    txf_rd_d  = tx_pop  ? txf_rd_q + AW'(1) : txf_rd_q;
    txf_cnt_d = txf_cnt_q + CW'(tx_push) - CW'(tx_pop);
  end

  // RX sampling on registered-clock falling edge, word assembly and RX FIFO
  always_comb begin
    rx_clk_in = sspclkin;
    rx_fss_in = sspfssin;
    rx_dat_in = ssprxd;
`ifdef SSP_LOOPBACK_EN
    if (loopback) begin
      rx_clk_in = sclk_q;
      rx_fss_in = fss_q;
      rx_dat_in = txd_q;
    end
`endif
    rclk_d     = rx_clk_in;
    sample     = rclk_q & ~rx_clk_in;
    rx_word    = {rx_shift_q, rx_dat_in};
    rx_push    = 1'b0;
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_cnt_d   = rx_cnt_q;
    if (sample) begin
      case (rx_state_q)
        RX_HUNT: begin
          if (rx_fss_in) begin
            rx_state_d = RX_RECV;
            rx_cnt_d   = '0;
          end
        end
        RX_RECV: begin
          if (rx_fss_in && (rx_cnt_q != BW'(WIDTH - 1))) begin
            rx_cnt_d = '0;
          end else begin
            rx_shift_d = rx_word[WIDTH-2:0];
            if (rx_cnt_q == BW'(WIDTH - 1)) begin
              rx_push    = 1'b1;
              rx_cnt_d   = '0;
              rx_state_d = RX_HUNT;
            end else begin
              rx_cnt_d = rx_cnt_q + BW'(1);
            end
          end
        end
        default: rx_state_d = RX_HUNT;
      endcase
    end

    rx_valid  = (rxf_cnt_q != '0);
    rx_pop    = rx_valid & rx_ready;
    rxf_full  = (rxf_cnt_q == CW'(DEPTH));
    rx_wr     = rx_push & (~rxf_full | rx_pop);
    ovr_d     = ovr_q | (rx_push & rxf_full & ~rx_pop);
    rxf_wr_d  = rx_wr  ? rxf_wr_q + AW'(1) : rxf_wr_q;
    rxf_rd_d  = rx_pop ? rxf_rd_q + AW'(1) : rxf_rd_q;
    rxf_cnt_d = rxf_cnt_q + CW'(rx_wr) - CW'(rx_pop);
    // rxdata is the registered head; a word landing in an otherwise empty
    // FIFO bypasses the memory so it appears together with rx_valid.
    rxdata_d  = rxdata_q;
    if (rxf_cnt_d != '0) begin
      if (rx_wr && (rxf_wr_q == rxf_rd_d)) rxdata_d = rx_word;
      else                                 rxdata_d = rxf_mem_q[rxf_rd_d];
    end
  end

  // State registers with synchronous clear
  always_ff @(posedge pclk) begin
    if (clear) begin
      sclk_q      <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_shift_q  <= '0;
      tx_bitcnt_q <= '0;
      fss_q       <= 1'b0;
      txd_q       <= 1'b0;
      oe_b_q      <= 1'b1;
      txf_wr_q    <= '0;
      txf_rd_q    <= '0;
      txf_cnt_q   <= '0;
      rclk_q      <= 1'b0;
      rx_state_q  <= RX_HUNT;
      rx_shift_q  <= '0;
      rx_cnt_q    <= '0;
      rxf_wr_q    <= '0;
      rxf_rd_q    <= '0;
      rxf_cnt_q   <= '0;
      rxdata_q    <= '0;
      ovr_q       <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_bitcnt_q <= tx_bitcnt_d;
      fss_q       <= fss_d;
      txd_q       <= txd_d;
      oe_b_q      <= oe_b_d;
      txf_wr_q    <= txf_wr_d;
      txf_rd_q    <= txf_rd_d;
      txf_cnt_q   <= txf_cnt_d;
      rclk_q      <= rclk_d;
      rx_state_q  <= rx_state_d;
      rx_shift_q  <= rx_shift_d;
      rx_cnt_q    <= rx_cnt_d;
      rxf_wr_q    <= rxf_wr_d;
      rxf_rd_q    <= rxf_rd_d;
      rxf_cnt_q   <= rxf_cnt_d;
      rxdata_q    <= rxdata_d;
      ovr_q       <= ovr_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers are flushed
  always_ff @(posedge pclk) begin
    if (!clear && tx_push) txf_mem_q[txf_wr_q] <= txdata;
    if (!clear && rx_wr)   rxf_mem_q[rxf_wr_q] <= rx_word;
  end

  assign sspclkout  = sclk_q;
  assign sspfssout  = fss_q;
  assign ssptxd     = txd_q;
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign rxdata     = rxdata_q;
  assign rx_overrun = ovr_q;
`ifdef SSP_LOOPBACK_EN
  assign sspoe_b    = oe_b_q | loopback;
`else
  assign sspoe_b    = oe_b_q;
`endif

endmodule
